booth_r4_seq_mult: RTL

//  Sequential radix-4 Booth multiplier that encodes the multiplier and drives the mux side.

---
 rtl/booth_r4_seq_mult.sv | 131 +++++++++++++
 1 files changed

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier.
// A {acc, mplier} register is scanned two bits per cycle. The current triplet
// {b[2i+1], b[2i], b[2i-1]} yields the Booth controls X2/A/S. These select
// +-M, +-2M or 0, which is added into the upper W+2 bits. The whole register
// then shifts right arithmetically by two.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. in_ready is high only in IDLE. out_valid is high only in DONE, and
// out_prod is held stable until the out transfer completes.
module booth_r4_seq_mult #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_mcand,
  input  logic [W-1:0]   in_mplier,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_prod,
  output logic           enc_x2,
  output logic           enc_a,
  output logic           enc_s
);

  localparam int STEPS = W / 2;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W+1:0]    acc_q, acc_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic            bm1_q, bm1_d;
  logic [CW-1:0]   step_q, step_d;

  logic [2:0]      trip;
  logic [W+1:0]    mag;
  logic [W+1:0]    pp;
  logic [W+1:0]    sum;
  logic [2*W+1:0]  shifted;

  // Booth encoding of the current triplet; active only while stepping
  always_comb begin
    trip   = {mplier_q[1:0], bm1_q};
    enc_x2 = 1'b0;
    enc_a  = 1'b0;
    enc_s  = 1'b0;
    if (state_q == RUN) begin
      enc_x2 = (trip == 3'b100) | (trip == 3'b011);
      enc_a  = ~trip[2] & (trip[1] | trip[0]);
      enc_s  = trip[2] & ~(trip[1] & trip[0]);
    end
  end

  // Partial-product mux, accumulate, and arithmetic shift right by two
  always_comb begin
    if (enc_x2) mag = {mcand_q[W-1], mcand_q, 1'b0};
    else        mag = {{2{mcand_q[W-1]}}, mcand_q};
    if (enc_s)      pp = -mag;
    else if (enc_a) pp = mag;
    else            pp = '0;
    sum     = acc_q + pp;
    shifted = {sum[W+1], sum[W+1], sum, mplier_q[W-1:2]};
  end

  // Next-state and register updates for the IDLE/RUN/DONE controller
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    bm1_d    = bm1_q;
    step_d   = step_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = in_mcand;
          mplier_d = in_mplier;
          bm1_d    = 1'b0;
          acc_d    = '0;
          step_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = shifted[2*W+1:W];
        mplier_d = shifted[W-1:0];
        bm1_d    = mplier_q[1];
        step_d   = step_q + 1'b1;
        if (step_q == LAST_STEP) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      bm1_q    <= 1'b0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      bm1_q    <= bm1_d;
      step_q   <= step_d;
    end
  end

  // After the final shift the product sits in the low 2W bits of {acc, mplier}
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_prod  = {acc_q[W-1:0], mplier_q};

endmodule
